exp_ts_capture: RTL and testbench

//  Timestamps edges on expansion-connector inputs using the 64-bit housekeeping timestamp counter.

---
 rtl/exp_ts_capture.sv | 150 +++++++++++++++
 tb/tb_exp_ts_capture.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/exp_ts_capture.sv
// Expansion-input edge timestamper: synchronizes the pins, detects masked edges and queues
// {timestamp, fall, rise} entries in a FIFO that software drains through the system bus.
module exp_ts_capture #(
    parameter int DWE     = 8,
    parameter int FIFO_AW = 4
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [63:0] timestamp_i,
    input  logic [DWE-1:0] exp_dat_i,
    input  logic [31:0] sys_addr,
    input  logic [31:0] sys_wdata,
    input  logic        sys_wen,
    input  logic        sys_ren,
    output logic [31:0] sys_rdata,
    output logic        sys_err,
    output logic        sys_ack,
    output logic        irq_o
);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int EW    = 64 + 2 * DWE;

    logic [DWE-1:0]     sync_a, sync_b, prev;
    logic [DWE-1:0]     rise_mask, fall_mask;
    logic [DWE-1:0]     rise, fall, rise_q, fall_q;
    logic               ev_q;
    logic               en, irq_en, ovf;
    logic [EW-1:0]      mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               empty, full;
    logic [19:0]        off;
    logic               wr_ctrl, wr_status, clr, pop, do_push;
    logic [EW-1:0]      head;
    logic [31:0]        rd_val;
    logic               unused_bits;

    assign off       = sys_addr[19:0];
    assign empty     = (count == '0);
    assign full      = count[FIFO_AW];
    assign wr_ctrl   = sys_wen && (off == 20'h00008);
    assign wr_status = sys_wen && (off == 20'h0000C);
    assign clr       = wr_ctrl && sys_wdata[1];
    assign pop       = sys_ren && (off == 20'h00018) && !empty;
    assign do_push   = ev_q && (!full || pop) && !clr;
    assign sys_err   = 1'b0;
    assign unused_bits = ^{sys_addr[31:20], sys_wdata};

    assign rise = sync_b & ~prev & rise_mask;
    assign fall = ~sync_b & prev & fall_mask;

    // Edge flags are registered once more, so the capture cycle lands 3 clocks after the pin.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_a <= '0;
            sync_b <= '0;
            prev   <= '0;
            rise_q <= '0;
            fall_q <= '0;
            ev_q   <= 1'b0;
        end else begin
            sync_a <= exp_dat_i;
            sync_b <= sync_a;
            prev   <= sync_b;
            rise_q <= rise;
            fall_q <= fall;
            ev_q   <= en && ((rise | fall) != '0);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rise_mask <= '0;
            fall_mask <= '0;
            en        <= 1'b0;
            irq_en    <= 1'b0;
        end else begin
            if (sys_wen && off == 20'h00000) rise_mask <= sys_wdata[DWE-1:0];
            if (sys_wen && off == 20'h00004) fall_mask <= sys_wdata[DWE-1:0];
            if (wr_ctrl) begin
                en     <= sys_wdata[0];
                irq_en <= sys_wdata[2];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= {timestamp_i, fall_q, rise_q};
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !pop)      count <= count + 1'b1;
            else if (!do_push && pop) count <= count - 1'b1;
        end
    end

    // A dropped event wins over a simultaneous write-1-to-clear so it is never lost silently.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)                                ovf <= 1'b0;
        else if (ev_q && full && !pop && !clr)      ovf <= 1'b1;
        else if (wr_status && sys_wdata[18])        ovf <= 1'b0;
    end

    assign head = empty ? '0 : mem[rd_ptr];

    always_comb begin
        rd_val = '0;
        case (off)
            20'h00000: rd_val[DWE-1:0] = rise_mask;
            20'h00004: rd_val[DWE-1:0] = fall_mask;
            20'h00008: begin
                rd_val[0] = en;
                rd_val[2] = irq_en;
            end
            20'h0000C: begin
                rd_val[FIFO_AW:0] = count;
                rd_val[16]        = empty;
                rd_val[17]        = full;
                rd_val[18]        = ovf;
            end
            20'h00010: rd_val = head[2*DWE+31:2*DWE];
            20'h00014: rd_val = head[EW-1:2*DWE+32];
            20'h00018: rd_val[2*DWE-1:0] = head[2*DWE-1:0];
            default:   rd_val = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sys_ack   <= 1'b0;
            sys_rdata <= '0;
            irq_o     <= 1'b0;
        end else begin
            sys_ack   <= sys_wen | sys_ren;
            sys_rdata <= sys_ren ? rd_val : 32'h0;
            irq_o     <= irq_en && !empty;
        end
    end
endmodule

// File: tb/tb_exp_ts_capture.sv
// Directed bench for exp_ts_capture: a queue-based model checked every cycle plus literal checks.
module tb_exp_ts_capture;
    localparam int DEPTH = 16;
    localparam logic [31:0] BASE = 32'h4030_0000;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic [63:0] timestamp_i = 64'd0;
    logic [7:0]  exp_dat_i = 8'h00;
    logic [31:0] sys_addr = 32'h0;
    logic [31:0] sys_wdata = 32'h0;
    logic        sys_wen = 1'b0;
    logic        sys_ren = 1'b0;
    logic [31:0] sys_rdata;
    logic        sys_err;
    logic        sys_ack;
    logic        irq_o;

    int checks = 0;
    int errors = 0;

    exp_ts_capture #(.DWE(8), .FIFO_AW(4)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .timestamp_i(timestamp_i), .exp_dat_i(exp_dat_i),
        .sys_addr(sys_addr), .sys_wdata(sys_wdata), .sys_wen(sys_wen), .sys_ren(sys_ren),
        .sys_rdata(sys_rdata), .sys_err(sys_err), .sys_ack(sys_ack), .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) timestamp_i <= timestamp_i + 64'd1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed { logic [63:0] ts; logic [15:0] flg; } ent_t;
    typedef struct { int due; ent_t e; } pend_t;
    ent_t  mq[$];
    pend_t pq[$];
    logic [7:0]  m_rise, m_fall, m_pin_prev;
    logic        m_en, m_irqen, m_ovf, m_irq, m_ack;
    logic [31:0] m_rdata;
    int          cyc;

    always @(posedge clk_i or negedge rstn_i) begin : model
        logic [19:0] off;
        logic [31:0] rv;
        logic [7:0]  r, f;
        logic        irq_n, push, pop, clr;
        pend_t       pe;
        if (!rstn_i) begin
            mq.delete(); pq.delete();
            m_rise = 0; m_fall = 0; m_pin_prev = 0; m_en = 0; m_irqen = 0; m_ovf = 0;
            m_irq = 0; m_ack = 0; m_rdata = 0; cyc = 0;
        end else begin
            cyc++;
            off = sys_addr[19:0];
            rv = 0;
            case (off)
                20'h00: rv = {24'h0, m_rise};
                20'h04: rv = {24'h0, m_fall};
                20'h08: rv = {29'h0, m_irqen, 1'b0, m_en};
                20'h0C: rv = {13'h0, m_ovf, (mq.size() == DEPTH), (mq.size() == 0), 11'h0, 5'(mq.size())};
                20'h10: rv = (mq.size() > 0) ? mq[0].ts[31:0] : 32'h0;
                20'h14: rv = (mq.size() > 0) ? mq[0].ts[63:32] : 32'h0;
                20'h18: rv = (mq.size() > 0) ? {16'h0, mq[0].flg} : 32'h0;
                default: rv = 0;
            endcase
            irq_n = m_irqen && (mq.size() != 0);
            // An edge seen on the pins becomes an entry three clocks later, stamped +3.
            r = exp_dat_i & ~m_pin_prev & m_rise;
            f = ~exp_dat_i & m_pin_prev & m_fall;
            if (m_en && (r | f) != 0) begin
                pe.due = cyc + 3;
                pe.e   = '{ts: timestamp_i + 64'd3, flg: {f, r}};
                pq.push_back(pe);
            end
            m_pin_prev = exp_dat_i;
            push = 0;
            if (pq.size() > 0 && pq[0].due == cyc) begin
                pe = pq.pop_front();
                push = 1;
            end
            pop = sys_ren && off == 20'h18 && mq.size() > 0;
            clr = sys_wen && off == 20'h08 && sys_wdata[1];
            if (sys_wen && off == 20'h0C && sys_wdata[18]) m_ovf = 0;
            if (clr) mq.delete();
            else begin
                if (pop) void'(mq.pop_front());
                if (push) begin
                    if (mq.size() < DEPTH) mq.push_back(pe.e);
                    else m_ovf = 1;
                end
            end
            if (sys_wen && off == 20'h00) m_rise = sys_wdata[7:0];
            if (sys_wen && off == 20'h04) m_fall = sys_wdata[7:0];
            if (sys_wen && off == 20'h08) begin m_en = sys_wdata[0]; m_irqen = sys_wdata[2]; end
            m_irq   = irq_n;
            m_ack   = sys_wen | sys_ren;
            m_rdata = sys_ren ? rv : 32'h0;
        end
    end

    always @(negedge clk_i) begin
        chk("irq_o", 64'(irq_o), 64'(m_irq));
        chk("sys_ack", 64'(sys_ack), 64'(m_ack));
        chk("sys_err", 64'(sys_err), 64'd0);
        if (m_ack) chk("sys_rdata", 64'(sys_rdata), 64'(m_rdata));
    end

    // ---------------- stimulus ----------------
    task automatic bus_write(input logic [19:0] off, input logic [31:0] data);
        sys_addr = BASE | 32'(off); sys_wdata = data; sys_wen = 1'b1;
        @(posedge clk_i); #1;
        sys_wen = 1'b0;
    endtask

    task automatic bus_read(input logic [19:0] off, output logic [31:0] data);
        sys_addr = BASE | 32'(off); sys_ren = 1'b1;
        @(posedge clk_i); #1;
        sys_ren = 1'b0;
        @(negedge clk_i);
        chk("ack_after_ren", 64'(sys_ack), 64'd1);
        data = sys_rdata;
        @(posedge clk_i); #1;
    endtask

    task automatic rd_chk(input string name, input logic [19:0] off, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(off, d);
        chk(name, 64'(d), 64'(exp));
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk_i); #1; end
    endtask

    task automatic pulse_then_read_at_push(input logic [19:0] off, input logic wr, input logic [31:0] wdata,
                                           output logic [31:0] data);
        exp_dat_i = exp_dat_i ^ 8'h01;
        idle(3);
        data = 0;
        if (wr) bus_write(off, wdata);
        else    bus_read(off, data);
    endtask

    initial begin
        logic [63:0] t0, t1, t2;
        logic [31:0] d;
        int          guard;
        repeat (3) @(posedge clk_i);
        #1;
        chk("reset_irq", 64'(irq_o), 64'd0);
        chk("reset_ack", 64'(sys_ack), 64'd0);
        chk("reset_rdata", 64'(sys_rdata), 64'd0);
        rstn_i = 1'b1;
        idle(1);
        rd_chk("status_after_reset", 20'h0C, 32'h0001_0000);

        // single rising edge stamped at 1000
        bus_write(20'h00, 32'h01);
        bus_write(20'h08, 32'h01);
        guard = 0;
        while (timestamp_i < 64'd1000 && guard < 2000) begin idle(1); guard++; end
        chk("ts_reached_1000", timestamp_i, 64'd1000);
        exp_dat_i = 8'h01;
        idle(1);
        exp_dat_i = 8'h00;
        idle(6);
        rd_chk("t1_status", 20'h0C, 32'h0000_0001);
        rd_chk("t1_tsl", 20'h10, 32'd1003);
        rd_chk("t1_tsh", 20'h14, 32'd0);
        rd_chk("t1_flg", 20'h18, 32'h0001);
        rd_chk("t1_status_empty", 20'h0C, 32'h0001_0000);

        // simultaneous rise on bit0 and fall on bit7
        bus_write(20'h04, 32'h80);
        exp_dat_i = 8'h80;
        idle(6);
        rd_chk("t2_masked_rise", 20'h0C, 32'h0001_0000);
        exp_dat_i = 8'h01;
        idle(6);
        rd_chk("t2_status", 20'h0C, 32'h0000_0001);
        rd_chk("t2_flg", 20'h18, 32'h8001);
        exp_dat_i = 8'h00;
        idle(6);

        // overflow with 17 edges into 16 slots
        bus_write(20'h00, 32'hFF);
        bus_write(20'h04, 32'hFF);
        idle(2);
        t0 = timestamp_i;
        for (int i = 0; i < 17; i++) begin exp_dat_i = exp_dat_i ^ 8'h01; idle(1); end
        idle(6);
        rd_chk("t3_full_ovf", 20'h0C, 32'h0006_0010);
        for (int k = 0; k < 16; k++) begin
            rd_chk("t3_tsl", 20'h10, 32'(t0 + 64'd3 + 64'(k)));
            rd_chk("t3_flg", 20'h18, (k % 2 == 0) ? 32'h0001 : 32'h0100);
        end
        rd_chk("t3_empty_ovf", 20'h0C, 32'h0005_0000);
        bus_write(20'h0C, 32'h0004_0000);
        rd_chk("t3_ovf_cleared", 20'h0C, 32'h0001_0000);

        // push and pop on the same edge while full
        t1 = timestamp_i;
        for (int i = 0; i < 16; i++) begin exp_dat_i = exp_dat_i ^ 8'h01; idle(1); end
        idle(6);
        rd_chk("t4_full", 20'h0C, 32'h0002_0010);
        t2 = timestamp_i;
        pulse_then_read_at_push(20'h18, 1'b0, 32'h0, d);
        chk("t4_pop_flg", 64'(d), 64'h0100);
        idle(3);
        rd_chk("t4_still_full", 20'h0C, 32'h0002_0010);
        for (int k = 0; k < 16; k++) begin
            if (k == 15) rd_chk("t4_last_tsl", 20'h10, 32'(t2 + 64'd3));
            else         rd_chk("t4_tsl", 20'h10, 32'(t1 + 64'd4 + 64'(k)));
            bus_read(20'h18, d);
        end
        rd_chk("t4_drained", 20'h0C, 32'h0001_0000);

        // clr colliding with a capture
        bus_write(20'h1C, 32'hFFFF_FFFF);
        rd_chk("unmapped", 20'h1C, 32'h0);
        bus_write(20'h08, 32'h07);
        rd_chk("ctrl_clr_reads0", 20'h08, 32'h05);
        exp_dat_i = exp_dat_i ^ 8'h01;
        idle(6);
        chk("t5_irq_set", 64'(irq_o), 64'd1);
        pulse_then_read_at_push(20'h08, 1'b1, 32'h02, d);
        idle(2);
        chk("t5_irq_clr", 64'(irq_o), 64'd0);
        rd_chk("t5_status", 20'h0C, 32'h0001_0000);
        rd_chk("t5_tsl_empty", 20'h10, 32'h0);

        // disabled capture, then async reset mid-stream
        bus_write(20'h08, 32'h04);
        for (int i = 0; i < 6; i++) begin exp_dat_i = exp_dat_i ^ 8'hFF; idle(1); end
        idle(6);
        chk("t6_irq_off", 64'(irq_o), 64'd0);
        rd_chk("t6_no_entries", 20'h0C, 32'h0001_0000);
        bus_write(20'h08, 32'h05);
        exp_dat_i = exp_dat_i ^ 8'hFF;
        idle(6);
        chk("t6_irq_on", 64'(irq_o), 64'd1);
        sys_addr = BASE | 32'h0C; sys_ren = 1'b1;
        @(posedge clk_i); #1;
        sys_ren = 1'b0;
        #1;
        rstn_i = 1'b0;
        #1;
        chk("t6_rst_irq", 64'(irq_o), 64'd0);
        chk("t6_rst_ack", 64'(sys_ack), 64'd0);
        chk("t6_rst_rdata", 64'(sys_rdata), 64'd0);
        @(posedge clk_i); #1;
        rstn_i = 1'b1;
        idle(1);
        rd_chk("t6_mask_cleared", 20'h00, 32'h0);
        rd_chk("t6_ctrl_cleared", 20'h08, 32'h0);
        rd_chk("t6_status_empty", 20'h0C, 32'h0001_0000);
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
